// File: rtl/fifo_packetizer_pkg.sv
// Shared types and constants for the FIFO packetizer: FSM state encoding,
// default sync byte, frame overhead sizes and an index-width helper.
package fifo_packetizer_pkg;

    // One state per byte class of the outgoing frame, plus FILL for buffering.
    typedef enum logic [2:0] {
        FILL,
        SYNC,
        SEQ,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Sync, sequence and length bytes ahead of the payload.
    localparam int HDR_BYTES = 3;

    // Checksum byte after the payload.
    localparam int TRAILER_BYTES = 1;

    // Width of a counter that must hold values 0..v-1, never narrower than 1.
    function automatic int idx_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fifo_packetizer_wordser.sv
// Payload word serializer: walks the packet buffer byte by byte, MSB byte of
// each word first, and flags when the byte just handed out was the last one.
module fifo_packetizer_wordser
    import fifo_packetizer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PKT_WORDS = 8,
    parameter int CNT_W     = idx_w(PKT_WORDS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr,
    input  logic                             adv,
    input  logic [CNT_W-1:0]                 len,
    input  logic [PKT_WORDS-1:0][WIDTH-1:0]  pkt_buf,
    output logic [7:0]                       byte_out,
    output logic                             done
);

    localparam int BPW    = WIDTH / 8;
    localparam int PIDX_W = idx_w(PKT_WORDS * BPW + 1);
    localparam int WIDX_W = idx_w(PKT_WORDS + 1);
    localparam int BK_W   = idx_w(BPW);
    localparam logic [BK_W-1:0] BK_LAST = BK_W'(BPW - 1);

    // pidx counts payload bytes already handed out; word_idx/byte_k point at
    // the next byte to hand out.
    logic [PIDX_W-1:0] pidx;
    logic [WIDX_W-1:0] word_idx;
    logic [BK_W-1:0]   byte_k;
    logic [WIDTH-1:0]  word_sel;
    logic [PIDX_W-1:0] total;

    assign total = PIDX_W'(len) * PIDX_W'(BPW);

    // Once every payload byte has been handed out, the byte currently on the
    // output register is the last one.
    assign done = (pidx == total);

    // Advance byte/word pointers on each payload byte taken by the top.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pidx     <= '0;
            word_idx <= '0;
            byte_k   <= '0;
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            pidx <= pidx + PIDX_W'(1);
            if (byte_k == BK_LAST) begin
                byte_k   <= '0;
                word_idx <= word_idx + WIDX_W'(1);
            end else begin
                byte_k <= byte_k + BK_W'(1);
            end
        end
    end

    // Select the pointed word (mux loop keeps the index in range) and its
    // byte, counting bytes from the MSB end.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        word_sel = pkt_buf[0];
        for (int w = 0; w < PKT_WORDS; w++) begin
            if (word_idx == WIDX_W'(w)) word_sel = pkt_buf[w];
        end
        byte_out = 8'(word_sel >> (8 * (BPW - 1 - int'(byte_k))));
    end

endmodule

// File: rtl/fifo_packetizer.sv
// FIFO packetizer top: buffers one packet of FIFO words, then emits
// SYNC, seq, LEN, payload (MSB byte first) and an XOR checksum as a
// valid/ready byte stream. The optional partial-packet flush on idle timeout
// is enabled by defining FIFO_PACKETIZER_FLUSH_TIMEOUT_EN.
module fifo_packetizer
    import fifo_packetizer_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         PKT_WORDS = 8,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_nempty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    output logic             busy
);

    localparam int CNT_W = idx_w(PKT_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);

    // Reject unsupported configurations at elaboration.
    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("fifo_packetizer: WIDTH must be a multiple of 8 in 8..64");
    end
    if (PKT_WORDS < 1 || PKT_WORDS > 255) begin : g_bad_words
        $error("fifo_packetizer: PKT_WORDS must be in 1..255");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fifo_packetizer: TIMEOUT must be at least 2");
    end

    state_t                          state, state_n;
    logic [CNT_W-1:0]                count;
    logic [PKT_WORDS-1:0][WIDTH-1:0] pkt_buf;
    logic [7:0]                      seq;
    logic [7:0]                      csum, csum_n;
    logic [7:0]                      tx_data_n;
    logic                            tx_valid_n, tx_last_n;
    logic                            xfer;
    logic                            flush_req;
    logic                            ser_adv, ser_done;
    logic [7:0]                      ser_byte;
    logic                            pkt_end;

    assign xfer     = tx_valid && tx_ready;
    assign fifo_pop = !reset && (state == FILL) && fifo_nempty && (count <= LAST_WORD);
    assign busy     = (state != FILL);

`ifdef FIFO_PACKETIZER_FLUSH_TIMEOUT_EN
    localparam int IDLE_W = idx_w(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Idle counter runs only while a partial packet waits in FILL.
    always_ff @(posedge clk) begin
        if (reset || state != FILL || count == '0 || fifo_pop) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign flush_req = (state == FILL) && (count != '0) && !fifo_pop && (idle_cnt == IDLE_LAST);
`else
    assign flush_req = 1'b0;
`endif

    fifo_packetizer_wordser #(
        .WIDTH     (WIDTH),
        .PKT_WORDS (PKT_WORDS),
        .CNT_W     (CNT_W)
    ) u_wordser (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == FILL),
        .adv      (ser_adv),
        .len      (count),
        .pkt_buf  (pkt_buf),
        .byte_out (ser_byte),
        .done     (ser_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_n;
    end

    // Next state and next output byte: each transfer loads the following
    // byte of the frame so the sink sees no gap while tx_ready stays high.
    always_comb begin
        state_n    = state;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        tx_last_n  = tx_last;
        csum_n     = csum;
        ser_adv    = 1'b0;
        pkt_end    = 1'b0;
        unique case (state)
            FILL: begin
                if ((fifo_pop && count == LAST_WORD) || flush_req) begin
                    state_n    = SYNC;
                    tx_valid_n = 1'b1;
                    tx_data_n  = SYNC_BYTE;
                    tx_last_n  = 1'b0;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_n   = SEQ;
                    tx_data_n = seq;
                    csum_n    = seq;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_n   = LEN;
                    tx_data_n = 8'(count);
                    csum_n    = csum ^ 8'(count);
                end
            end
            LEN: begin
                if (xfer) begin
                    state_n   = PAYLOAD;
                    tx_data_n = ser_byte;
                    csum_n    = csum ^ ser_byte;
                    ser_adv   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (ser_done) begin
                        state_n   = CSUM;
                        tx_data_n = csum;
                        tx_last_n = 1'b1;
                    end else begin
                        tx_data_n = ser_byte;
                        csum_n    = csum ^ ser_byte;
                        ser_adv   = 1'b1;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_n    = FILL;
                    tx_valid_n = 1'b0;
                    tx_last_n  = 1'b0;
                    tx_data_n  = 8'h00;
                    pkt_end    = 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // Output register, checksum accumulator, sequence number and word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_last  <= 1'b0;
            csum     <= 8'h00;
            seq      <= 8'h00;
            count    <= '0;
        end else begin
            tx_valid <= tx_valid_n;
            tx_data  <= tx_data_n;
            tx_last  <= tx_last_n;
            csum     <= csum_n;
            if (pkt_end) begin
                seq   <= seq + 8'd1;
                count <= '0;
            end else if (fifo_pop) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Packet buffer write on each pop.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is storage, not control state; it has no reset
        // because count decides which entries are meaningful.
        if (fifo_pop) pkt_buf[count] <= fifo_data;
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Self-checking bench for fifo_packetizer: a queue-based FIFO source and a
// frame-level reference model built from the packet format rules.
// Define FIFO_PACKETIZER_FLUSH_TIMEOUT_EN to exercise the timeout flush.
module tb_fifo_packetizer;

    localparam int         WIDTH     = 16;
    localparam int         PKT_WORDS = 4;
    localparam int         TIMEOUT   = 16;
    localparam int         BPW       = WIDTH / 8;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic             clk = 1'b0;
    logic             reset;
    logic             fifo_nempty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             busy;

    always #5 clk = ~clk;

    fifo_packetizer #(
        .WIDTH     (WIDTH),
        .PKT_WORDS (PKT_WORDS),
        .SYNC_BYTE (SYNC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_nempty (fifo_nempty),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source FIFO contents, expected and received byte streams.
    logic [WIDTH-1:0] src_q[$];
    logic [7:0]       exp_b[$];
    logic [7:0]       rx_b[$];
    bit               exp_l[$];
    bit               rx_l[$];
    logic [7:0]       m_seq = 8'h00;

    int  gate_mode  = 0;   // 0: nempty whenever data, 1: gated every other cycle
    int  ready_mode = 0;   // 0: always ready, 1: random, 2: ready until ready_stop transfers
    int  ready_stop = 0;
    bit  gate_tog   = 1'b0;
    int  cyc = 0, last_pop_cyc = -100, rise_cyc = -1, run_len = 0, last_run = 0;
    int  valid_cycles = 0, xfers = 0;
    bit  prev_stall = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_d;
    logic       prev_last;
    logic       pop_seen;

    // Reference frame: SYNC, seq, LEN, payload MSB first, XOR of all but SYNC.
    task automatic send_packet(input logic [WIDTH-1:0] words[$]);
        logic [7:0]       cs, b;
        logic [WIDTH-1:0] w;
        exp_b.push_back(SYNC);                 exp_l.push_back(1'b0);
        exp_b.push_back(m_seq);                exp_l.push_back(1'b0);
        cs = m_seq;
        exp_b.push_back(8'(words.size()));     exp_l.push_back(1'b0);
        cs = cs ^ 8'(words.size());
        foreach (words[i]) begin
            w = words[i];
            for (int k = BPW - 1; k >= 0; k--) begin
                b = w[8*k +: 8];
                exp_b.push_back(b); exp_l.push_back(1'b0);
                cs = cs ^ b;
            end
            src_q.push_back(w);
        end
        exp_b.push_back(cs);                   exp_l.push_back(1'b1);
        m_seq = m_seq + 8'd1;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_b.size() < n; i++) @(posedge clk);
        check({tag, "_count"}, rx_b.size(), n);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, rx_b.size(), exp_b.size());
        foreach (exp_b[i]) begin
            if (i < rx_b.size()) begin
                check($sformatf("%s_byte%0d", tag, i), rx_b[i], exp_b[i]);
                check($sformatf("%s_last%0d", tag, i), rx_l[i], exp_l[i]);
            end
        end
        rx_b.delete(); rx_l.delete(); exp_b.delete(); exp_l.delete();
    endtask

    // FIFO source, sink and protocol monitor: sample at negedge, drive after posedge.
    initial begin
        fifo_nempty = 1'b0;
        fifo_data   = '0;
        tx_ready    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            pop_seen = fifo_pop;
            if (!reset) begin
                if (fifo_pop) begin
                    check("pop_needs_nempty", fifo_nempty, 1'b1);
                    last_pop_cyc = cyc;
                end
                if (tx_valid) begin
                    check("no_pop_in_emit", fifo_pop, 1'b0);
                    valid_cycles++;
                end
                if (prev_stall && !prev_rst) begin
                    check("hold_valid", tx_valid, 1'b1);
                    check("hold_data", tx_data, prev_d);
                    check("hold_last", tx_last, prev_last);
                end
                if (tx_valid && run_len == 0) rise_cyc = cyc;
                if (tx_valid) run_len++;
                else if (run_len != 0) begin
                    last_run = run_len;
                    run_len  = 0;
                end
                if (tx_valid && tx_ready) begin
                    rx_b.push_back(tx_data);
                    rx_l.push_back(tx_last);
                    xfers++;
                end
            end else begin
                run_len = 0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_d     = tx_data;
            prev_last  = tx_last;
            prev_rst   = reset;

            @(posedge clk);
            #1;
            if (pop_seen && src_q.size() != 0) void'(src_q.pop_front());
            gate_tog    = ~gate_tog;
            fifo_nempty = (src_q.size() != 0) && (gate_mode == 0 || gate_tog);
            fifo_data   = (src_q.size() != 0) ? src_q[0] : '0;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (xfers < ready_stop);
            endcase
        end
    end

    logic [WIDTH-1:0] wq[$];
    int v0;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_pop", fifo_pop, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed packet, sink always ready.
        wq = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        send_packet(wq);
        wait_bytes("t1", 12, 200);
        repeat (2) @(posedge clk);
        check("t1_first_valid_latency", rise_cyc, last_pop_cyc + 1);
        check("t1_valid_run", last_run, 12);
        compare_stream("t1");

        // Same words, random backpressure.
        ready_mode = 1;
        send_packet(wq);
        wait_bytes("t2", 12, 400);
        compare_stream("t2");

        // Random words, FIFO non-empty only every other cycle.
        ready_mode = 0;
        gate_mode  = 1;
        wq.delete();
        for (int i = 0; i < PKT_WORDS; i++) wq.push_back(WIDTH'($urandom));
        send_packet(wq);
        wait_bytes("t3", 12, 400);
        compare_stream("t3");
        gate_mode = 0;

        // Reset while the third payload byte is pending.
        ready_stop = xfers + 5;
        ready_mode = 2;
        wq.delete();
        for (int i = 0; i < PKT_WORDS; i++) wq.push_back(WIDTH'($urandom));
        send_packet(wq);
        for (int i = 0; i < 300 && xfers < ready_stop; i++) @(posedge clk);
        @(negedge clk);
        check("t5_pending_valid", tx_valid, 1'b1);
        check("t5_pending_byte", tx_data, exp_b[5]);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_valid_after_reset", tx_valid, 1'b0);
        check("t5_busy_after_reset", busy, 1'b0);
        rx_b.delete(); rx_l.delete(); exp_b.delete(); exp_l.delete();
        m_seq      = 8'h00;
        ready_mode = 0;

        // 257 back-to-back packets: seq 00..FF then wraps to 00.
        for (int p = 0; p < 257; p++) begin
            wq.delete();
            for (int i = 0; i < PKT_WORDS; i++) wq.push_back(WIDTH'($urandom));
            send_packet(wq);
        end
        wait_bytes("t4", 257 * 12, 6000);
        compare_stream("t4");

        // Partial packet: two words, then the FIFO runs dry.
        wq = '{16'hC0DE, 16'h0BAD};
        send_packet(wq);
`ifdef FIFO_PACKETIZER_FLUSH_TIMEOUT_EN
        wait_bytes("t6", 8, TIMEOUT + 60);
        repeat (2) @(posedge clk);
        check("t6_flush_latency", rise_cyc, last_pop_cyc + TIMEOUT + 1);
        compare_stream("t6");
`else
        v0 = valid_cycles;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("t6_no_flush_valid", valid_cycles - v0, 0);
        check("t6_busy", busy, 1'b0);
        check("t6_words_popped", src_q.size(), 0);
        exp_b.delete(); exp_l.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
